// File: rtl/argon_regfile_sequencer.sv
// Argon regfile bus initiator: LATCHSEL, READA, READB, then LATCHC. Operands are valid 4 cycles after request acceptance at the earliest.
// Each read stalls while i_BusValid is low and faults after RETRY_MAX consecutive stalls. Optional flags writeback: ARGON_SEQ_FLAGS_WB_EN.
module argon_regfile_sequencer #(
    parameter int                     WORD_WIDTH  = 16,
    parameter int                     INDEX_WIDTH = 3,
    parameter int                     CMD_WIDTH   = 4,
    parameter logic [CMD_WIDTH-1:0]   CMD_IDLE    = {CMD_WIDTH{1'b1}},
    parameter int                     RETRY_MAX   = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic                   i_ReqValid,
    output logic                   o_ReqReady,
    input  logic [INDEX_WIDTH-1:0] i_ReqSelA,
    input  logic [INDEX_WIDTH-1:0] i_ReqSelB,
    input  logic [INDEX_WIDTH-1:0] i_ReqSelC,
    input  logic                   i_ReqWb,
    output logic                   o_OpsValid,
    input  logic                   i_OpsReady,
    output logic [WORD_WIDTH-1:0]  o_OpA,
    output logic [WORD_WIDTH-1:0]  o_OpB,
    input  logic                   i_WbValid,
    output logic                   o_WbReady,
    input  logic [WORD_WIDTH-1:0]  i_WbData,
    input  logic [7:0]             i_WbFlags,
    output logic [CMD_WIDTH-1:0]   o_BusCmd,
    output logic [WORD_WIDTH-1:0]  o_BusData,
    output logic                   o_BusValid,
    input  logic [WORD_WIDTH-1:0]  i_BusData,
    input  logic                   i_BusValid,
    output logic                   o_Busy,
    output logic                   o_Fault
);
    // Regfile command encodings; CMD_IDLE (all ones) never collides with these.
    localparam logic [CMD_WIDTH-1:0] COM_LATCHSEL = CMD_WIDTH'(0);
    localparam logic [CMD_WIDTH-1:0] COM_READA    = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0] COM_READB    = CMD_WIDTH'(2);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHC   = CMD_WIDTH'(3);
    localparam logic [CMD_WIDTH-1:0] COM_LATCHF   = CMD_WIDTH'(4);
    localparam int RW = $clog2(RETRY_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_RDA, S_RDB, S_OPS, S_WBW, S_WR
`ifdef ARGON_SEQ_FLAGS_WB_EN
        , S_WRF
`endif
    } state_t;

    state_t                 state, state_nxt;
    logic [INDEX_WIDTH-1:0] sel_a, sel_b, sel_c;
    logic                   wb_req;
    logic [WORD_WIDTH-1:0]  wb_data;
    logic [RW-1:0]          retry_cnt;
    logic                   retry_last;

    assign retry_last = (retry_cnt == RW'(RETRY_MAX - 1));

`ifdef ARGON_SEQ_FLAGS_WB_EN
    logic [7:0] wb_flags;
`else
    logic unused_flags;
    assign unused_flags = ^i_WbFlags;
`endif

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            state     <= S_IDLE;
            sel_a     <= '0;
            sel_b     <= '0;
            sel_c     <= '0;
            wb_req    <= 1'b0;
            wb_data   <= '0;
            retry_cnt <= '0;
            o_OpA     <= '0;
            o_OpB     <= '0;
            o_Fault   <= 1'b0;
`ifdef ARGON_SEQ_FLAGS_WB_EN
            wb_flags  <= '0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (i_ReqValid) begin
                    sel_a  <= i_ReqSelA;
                    sel_b  <= i_ReqSelB;
                    sel_c  <= i_ReqSelC;
                    wb_req <= i_ReqWb;
                end
                S_SEL: retry_cnt <= '0;
                S_RDA: begin
                    if (i_BusValid) begin
                        o_OpA     <= i_BusData;
                        retry_cnt <= '0;
                    end else if (retry_last) begin
                        o_Fault   <= 1'b1;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                    end
                end
                S_RDB: begin
                    if (i_BusValid) begin
                        o_OpB     <= i_BusData;
                        retry_cnt <= '0;
                    end else if (retry_last) begin
                        o_Fault   <= 1'b1;
                    end else begin
                        retry_cnt <= retry_cnt + 1'b1;
                    end
                end
                S_WBW: if (i_WbValid) begin
                    wb_data  <= i_WbData;
`ifdef ARGON_SEQ_FLAGS_WB_EN
                    wb_flags <= i_WbFlags;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (i_ReqValid) state_nxt = S_SEL;
            S_SEL:  state_nxt = S_RDA;
            S_RDA:  if (i_BusValid) state_nxt = S_RDB;
                    else if (retry_last) state_nxt = S_IDLE;
            S_RDB:  if (i_BusValid) state_nxt = S_OPS;
                    else if (retry_last) state_nxt = S_IDLE;
            S_OPS:  if (i_OpsReady) state_nxt = wb_req ? S_WBW : S_IDLE;
            S_WBW:  if (i_WbValid) begin
`ifdef ARGON_SEQ_FLAGS_WB_EN
                state_nxt = (sel_c == '0) ? S_WRF : S_WR;
`else
                state_nxt = (sel_c == '0) ? S_IDLE : S_WR;
`endif
            end
`ifdef ARGON_SEQ_FLAGS_WB_EN
            S_WR:   state_nxt = S_WRF;
            S_WRF:  state_nxt = S_IDLE;
`else
            S_WR:   state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // All handshake and bus outputs decode from the state register only.
    always_comb begin
        o_BusCmd   = CMD_IDLE;
        o_BusData  = '0;
        o_BusValid = 1'b0;
        case (state)
            S_SEL: begin
                o_BusCmd                       = COM_LATCHSEL;
                o_BusData[3*INDEX_WIDTH-1:0]   = {sel_c, sel_b, sel_a};
                o_BusValid                     = 1'b1;
            end
            S_RDA: o_BusCmd = COM_READA;
            S_RDB: o_BusCmd = COM_READB;
            S_WR: begin
                o_BusCmd   = COM_LATCHC;
                o_BusData  = wb_data;
                o_BusValid = 1'b1;
            end
`ifdef ARGON_SEQ_FLAGS_WB_EN
            S_WRF: begin
                o_BusCmd       = COM_LATCHF;
                o_BusData[7:0] = wb_flags;
                o_BusValid     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign o_ReqReady = (state == S_IDLE);
    assign o_OpsValid = (state == S_OPS);
    assign o_WbReady  = (state == S_WBW);
    assign o_Busy     = (state != S_IDLE);

endmodule

// File: tb/tb_argon_regfile_sequencer.sv
// Scoreboarded bench for argon_regfile_sequencer: directed requests push expected bus writes and
// operand handoffs; a monitor pops and compares them as the DUT presents them.
module tb_argon_regfile_sequencer;
    localparam logic [3:0] COM_LATCHSEL = 4'h0;
    localparam logic [3:0] COM_READA    = 4'h1;
    localparam logic [3:0] COM_READB    = 4'h2;
    localparam logic [3:0] COM_LATCHC   = 4'h3;
    localparam logic [3:0] COM_LATCHF   = 4'h4;
    localparam logic [3:0] CMD_IDLE     = 4'hF;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_ReqValid = 1'b0;
    logic        o_ReqReady;
    logic [2:0]  i_ReqSelA = '0, i_ReqSelB = '0, i_ReqSelC = '0;
    logic        i_ReqWb = 1'b0;
    logic        o_OpsValid;
    logic        i_OpsReady = 1'b0;
    logic [15:0] o_OpA, o_OpB;
    logic        i_WbValid = 1'b0;
    logic        o_WbReady;
    logic [15:0] i_WbData = '0;
    logic [7:0]  i_WbFlags = '0;
    logic [3:0]  o_BusCmd;
    logic [15:0] o_BusData;
    logic        o_BusValid;
    logic [15:0] i_BusData;
    logic        i_BusValid;
    logic        o_Busy, o_Fault;

    argon_regfile_sequencer dut (
        .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
        .i_ReqValid(i_ReqValid), .o_ReqReady(o_ReqReady),
        .i_ReqSelA(i_ReqSelA), .i_ReqSelB(i_ReqSelB), .i_ReqSelC(i_ReqSelC), .i_ReqWb(i_ReqWb),
        .o_OpsValid(o_OpsValid), .i_OpsReady(i_OpsReady), .o_OpA(o_OpA), .o_OpB(o_OpB),
        .i_WbValid(i_WbValid), .o_WbReady(o_WbReady), .i_WbData(i_WbData), .i_WbFlags(i_WbFlags),
        .o_BusCmd(o_BusCmd), .o_BusData(o_BusData), .o_BusValid(o_BusValid),
        .i_BusData(i_BusData), .i_BusValid(i_BusValid), .o_Busy(o_Busy), .o_Fault(o_Fault)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        int         kind;   // 0: bus write strobe, 1: operand handoff
        logic [3:0] cmd;
        logic [15:0] d0;
        logic [15:0] d1;
    } ev_t;

    ev_t  exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Regfile model: answers reads for the indices latched by the last LATCHSEL.
    logic [15:0] rf [8];
    logic [2:0]  lat_a = '0, lat_b = '0;
    logic        bus_en = 1'b1;

    always @(posedge i_Clk)
        if (o_BusValid && o_BusCmd == COM_LATCHSEL) begin
            lat_a <= o_BusData[2:0];
            lat_b <= o_BusData[5:3];
        end

    always_comb begin
        i_BusData  = '0;
        i_BusValid = 1'b0;
        if (bus_en && o_BusCmd == COM_READA) begin
            i_BusData  = rf[lat_a];
            i_BusValid = 1'b1;
        end else if (bus_en && o_BusCmd == COM_READB) begin
            i_BusData  = rf[lat_b];
            i_BusValid = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [3:0] cmd, input logic [15:0] d0, input logic [15:0] d1);
        ev_t e;
        e.kind = kind; e.cmd = cmd; e.d0 = d0; e.d1 = d1;
        exp_q.push_back(e);
    endtask

    // Monitor samples 2 time units after the negedge so it sees the inputs the bench just drove.
    initial begin
        ev_t e;
        forever begin
            @(negedge i_Clk);
            #2;
            if (o_BusValid || (o_OpsValid && i_OpsReady)) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_event: got cmd 0x%0h data 0x%0h ops %0b, expected nothing",
                             o_BusCmd, o_BusData, o_OpsValid);
                end else begin
                    e = exp_q.pop_front();
                    if (o_BusValid) begin
                        check("ev_kind_bus", 0, e.kind);
                        check("bus_cmd", {28'h0, o_BusCmd}, {28'h0, e.cmd});
                        check("bus_data", {16'h0, o_BusData}, {16'h0, e.d0});
                    end else begin
                        check("ev_kind_ops", 1, e.kind);
                        check("op_a", {16'h0, o_OpA}, {16'h0, e.d0});
                        check("op_b", {16'h0, o_OpB}, {16'h0, e.d1});
                    end
                end
            end else if (o_BusData != 16'h0) begin
                check("idle_bus_data", {16'h0, o_BusData}, 32'h0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!o_ReqReady && n < 50) begin @(negedge i_Clk); n++; end
        check("reach_idle", {31'h0, o_ReqReady}, 32'h1);
    endtask

    task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic wb);
        i_ReqValid = 1'b1; i_ReqSelA = a; i_ReqSelB = b; i_ReqSelC = c; i_ReqWb = wb;
        @(negedge i_Clk);
        i_ReqValid = 1'b0;
    endtask

    task automatic run_txn(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic wb,
                           input logic [15:0] wd, input logic [7:0] fl,
                           input logic [15:0] esel, input logic [15:0] ea, input logic [15:0] eb,
                           input int delay);
        int cyc;
        wait_idle();
        push_ev(0, COM_LATCHSEL, esel, 16'h0);
        push_ev(1, 4'h0, ea, eb);
        if (wb && c != 3'd0) push_ev(0, COM_LATCHC, wd, 16'h0);
`ifdef ARGON_SEQ_FLAGS_WB_EN
        if (wb) push_ev(0, COM_LATCHF, {8'h00, fl}, 16'h0);
`endif
        issue(a, b, c, wb);
        cyc = 1;
        check("sel_cmd", {28'h0, o_BusCmd}, {28'h0, COM_LATCHSEL});
        while (!o_OpsValid && cyc < 20) begin @(negedge i_Clk); cyc++; end
        check("ops_latency", cyc, 4);
        for (int i = 0; i < delay; i++) begin
            check("hold_op_a", {16'h0, o_OpA}, {16'h0, ea});
            check("hold_op_b", {16'h0, o_OpB}, {16'h0, eb});
            check("hold_ops_valid", {31'h0, o_OpsValid}, 32'h1);
            check("hold_no_cmd", {27'h0, o_BusValid, o_BusCmd}, {28'h0, CMD_IDLE});
            @(negedge i_Clk);
        end
        i_OpsReady = 1'b1;
        @(negedge i_Clk);
        i_OpsReady = 1'b0;
        if (wb) begin
            cyc = 0;
            while (!o_WbReady && cyc < 10) begin @(negedge i_Clk); cyc++; end
            check("wb_ready", {31'h0, o_WbReady}, 32'h1);
            i_WbValid = 1'b1; i_WbData = wd; i_WbFlags = fl;
            @(negedge i_Clk);
            i_WbValid = 1'b0;
        end
        wait_idle();
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        rf[0] = 16'h0000; rf[1] = 16'h1234; rf[2] = 16'hBEEF; rf[3] = 16'h5A5A;
        rf[4] = 16'h0F0F; rf[5] = 16'hA5A5; rf[6] = 16'h1111; rf[7] = 16'h7777;

        // Reset state
        repeat (2) @(negedge i_Clk);
        check("rst_req_ready", {31'h0, o_ReqReady}, 32'h1);
        check("rst_ops_valid", {31'h0, o_OpsValid}, 32'h0);
        check("rst_wb_ready", {31'h0, o_WbReady}, 32'h0);
        check("rst_ops", {o_OpA, o_OpB}, 32'h0);
        check("rst_bus_cmd", {28'h0, o_BusCmd}, {28'h0, CMD_IDLE});
        check("rst_bus_data", {15'h0, o_BusValid, o_BusData}, 32'h0);
        check("rst_busy_fault", {30'h0, o_Busy, o_Fault}, 32'h0);
        i_Reset_n = 1'b1;
        @(negedge i_Clk);

        // Main path, C=0 writeback, stalled consumer, back-to-back accept after WR
        run_txn(3'd1, 3'd2, 3'd3, 1'b1, 16'h00FF, 8'h3C, 16'h00D1, 16'h1234, 16'hBEEF, 0);
        run_txn(3'd4, 3'd5, 3'd0, 1'b1, 16'hABCD, 8'h81, 16'h002C, 16'h0F0F, 16'hA5A5, 0);
        run_txn(3'd7, 3'd6, 3'd5, 1'b0, 16'h0000, 8'h00, 16'h0177, 16'h7777, 16'h1111, 5);

        // Read fault: regfile never answers READA
        wait_idle();
        bus_en = 1'b0;
        i_OpsReady = 1'b1;
        push_ev(0, COM_LATCHSEL, 16'h0163, 16'h0);
        issue(3'd3, 3'd4, 3'd5, 1'b1);
        cyc = 1;
        while (!o_Fault && cyc < 12) begin @(negedge i_Clk); cyc++; end
        check("fault_cycle", cyc, 5);
        check("fault_idle", {30'h0, o_ReqReady, o_OpsValid}, 32'h2);
        i_OpsReady = 1'b0;
        bus_en = 1'b1;
        run_txn(3'd2, 3'd1, 3'd7, 1'b1, 16'h8001, 8'h00, 16'h01CA, 16'hBEEF, 16'h1234, 0);
        check("fault_sticky", {31'h0, o_Fault}, 32'h1);

        // Reset during RDB aborts the sequence
        i_OpsReady = 1'b1;
        push_ev(0, COM_LATCHSEL, 16'h007E, 16'h0);
        issue(3'd6, 3'd7, 3'd1, 1'b1);
        @(negedge i_Clk);
        @(negedge i_Clk);
        check("in_rdb", {28'h0, o_BusCmd}, {28'h0, COM_READB});
        i_Reset_n = 1'b0;
        @(negedge i_Clk);
        i_Reset_n = 1'b1;
        check("abort_idle", {29'h0, o_Busy, o_ReqReady, o_OpsValid}, 32'h2);
        check("abort_ops", {o_OpA, o_OpB}, 32'h0);
        check("abort_fault_clr", {31'h0, o_Fault}, 32'h0);
        check("abort_cmd", {28'h0, o_BusCmd}, {28'h0, CMD_IDLE});
        repeat (6) @(negedge i_Clk);
        check("abort_quiet", {31'h0, o_Busy}, 32'h0);
        check("abort_queue", exp_q.size(), 0);
        i_OpsReady = 1'b0;

        run_txn(3'd1, 3'd2, 3'd3, 1'b1, 16'h00FF, 8'h3C, 16'h00D1, 16'h1234, 16'hBEEF, 0);

        repeat (3) @(negedge i_Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
